// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Registered MIPS program counter with next-PC selection, stall,
//             reset vector and a circular return-address stack.
//  Revision : 1.0  initial release
// ============================================================================
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic [2:0]       pc_sel,
   input  logic             is_zero,
   input  logic [WIDTH-1:0] da,
   input  logic [25:0]      addr,
   input  logic [15:0]      imm,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] next_pc,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow,
   output logic             ras_underflow,
   output logic             misalign_err
);

   localparam logic [2:0] c_SEL_SEQ  = 3'd0;
   localparam logic [2:0] c_SEL_BEQ  = 3'd1;
   localparam logic [2:0] c_SEL_BNE  = 3'd2;
   localparam logic [2:0] c_SEL_J    = 3'd3;
   localparam logic [2:0] c_SEL_JR   = 3'd4;
   localparam logic [2:0] c_SEL_CALL = 3'd5;
   localparam logic [2:0] c_SEL_RET  = 3'd6;

   localparam int                c_PTR_W = $clog2(RAS_DEPTH);
   localparam int                c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0]   r_pc;
   logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
   logic [c_PTR_W-1:0] r_ptr;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_overflow;
   logic               r_underflow;
   logic               r_misalign;

   logic [WIDTH-1:0]   w_pc_plus4;
   logic [WIDTH-1:0]   w_br_tgt;
   logic [WIDTH-1:0]   w_j_tgt;
   logic [WIDTH-1:0]   w_top;
   logic [WIDTH-1:0]   w_next;
   logic               w_empty;
   logic               w_full;
   logic               w_push;
   logic               w_pop;
   logic               w_underflow_ev;
   logic               w_misalign_ev;

   assign w_pc_plus4 = r_pc + WIDTH'(4);
   assign w_br_tgt   = w_pc_plus4 + {{(WIDTH-18){imm[15]}}, imm, 2'b00};
   assign w_j_tgt    = {w_pc_plus4[WIDTH-1:28], addr, 2'b00};
   // Pointer addresses the next free slot, so the top lives one below it.
   assign w_top      = r_ras[r_ptr - 1'b1];
   assign w_empty    = (r_cnt == '0);
   assign w_full     = (r_cnt == c_CNT_MAX);

   always_comb begin
      w_next         = w_pc_plus4;
      w_push         = 1'b0;
      w_pop          = 1'b0;
      w_underflow_ev = 1'b0;
      w_misalign_ev  = 1'b0;
      case (pc_sel)
         c_SEL_SEQ: w_next = w_pc_plus4;
         c_SEL_BEQ: if (is_zero)  w_next = w_br_tgt;
         c_SEL_BNE: if (!is_zero) w_next = w_br_tgt;
         c_SEL_J:   w_next = w_j_tgt;
         c_SEL_JR: begin
            w_next        = {da[WIDTH-1:2], 2'b00};
            w_misalign_ev = (da[1:0] != 2'b00);
         end
         c_SEL_CALL: begin
            w_next = w_j_tgt;
            w_push = 1'b1;
         end
         c_SEL_RET: begin
            if (!w_empty) begin
               w_next        = {w_top[WIDTH-1:2], 2'b00};
               w_pop         = 1'b1;
               w_misalign_ev = (w_top[1:0] != 2'b00);
            end else begin
               w_next         = {da[WIDTH-1:2], 2'b00};
               w_underflow_ev = 1'b1;
               w_misalign_ev  = (da[1:0] != 2'b00);
            end
         end
         default: w_next = w_pc_plus4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_VECTOR;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_misalign  <= 1'b0;
      end else if (!stall) begin
         r_pc <= w_next;
         if (w_push) begin
            r_ptr <= r_ptr + 1'b1;
            if (w_full) r_overflow <= 1'b1;
            else        r_cnt      <= r_cnt + 1'b1;
         end else if (w_pop) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_underflow_ev) r_underflow <= 1'b1;
         if (w_misalign_ev)  r_misalign  <= 1'b1;
      end
   end

   // Entry storage is not reset; count and pointer alone define validity.
   always_ff @(posedge clk) begin
      if (!stall && w_push) r_ras[r_ptr] <= w_pc_plus4;
   end

   assign pc            = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign next_pc       = w_next;
   assign ras_empty     = w_empty;
   assign ras_full      = w_full;
   assign ras_overflow  = r_overflow;
   assign ras_underflow = r_underflow;
   assign misalign_err  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed self-checking bench for pc_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_unit;

   localparam int          c_W  = 32;
   localparam logic [31:0] c_RV = 32'h0040_0000;

   localparam logic [2:0] c_SEQ  = 3'd0;
   localparam logic [2:0] c_BEQ  = 3'd1;
   localparam logic [2:0] c_BNE  = 3'd2;
   localparam logic [2:0] c_J    = 3'd3;
   localparam logic [2:0] c_JR   = 3'd4;
   localparam logic [2:0] c_CALL = 3'd5;
   localparam logic [2:0] c_RET  = 3'd6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            stall;
   logic [2:0]      pc_sel;
   logic            is_zero;
   logic [c_W-1:0]  da;
   logic [25:0]     addr;
   logic [15:0]     imm;
   logic [c_W-1:0]  pc;
   logic [c_W-1:0]  pc_plus4;
   logic [c_W-1:0]  next_pc;
   logic            ras_empty;
   logic            ras_full;
   logic            ras_overflow;
   logic            ras_underflow;
   logic            misalign_err;

   int n_cmp = 0;
   int n_err = 0;

   pc_unit #(
      .WIDTH        (c_W),
      .RESET_VECTOR (c_RV),
      .RAS_DEPTH    (4)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .pc_sel        (pc_sel),
      .is_zero       (is_zero),
      .da            (da),
      .addr          (addr),
      .imm           (imm),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_pc),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow),
      .misalign_err  (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one operation, clock it, and leave the bench 1 time unit past the edge.
   task automatic step(input logic [2:0] sel, input logic [31:0] d, input logic [25:0] a);
      pc_sel = sel;
      da     = d;
      addr   = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; pc_sel = c_SEQ; is_zero = 1'b0;
      da = '0; addr = '0; imm = '0;
      #12;
      check("rst_pc",        pc,            c_RV);
      check("rst_empty",     ras_empty,     1);
      check("rst_flags",     {ras_full, ras_overflow, ras_underflow, misalign_err}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("seq0", pc, 32'h0040_0004);
      step(c_SEQ, 0, 0); check("seq1", pc, 32'h0040_0008);
      step(c_SEQ, 0, 0); check("seq2", pc, 32'h0040_000C);

      // Branches from 0x100
      step(c_JR, 32'h100, 0);
      check("jr_100", pc, 32'h100);
      check("jr_noalign", misalign_err, 0);
      pc_sel = c_BEQ; imm = 16'hFFFE; is_zero = 1'b1; #1;
      check("beq_taken", next_pc, 32'hFC);
      is_zero = 1'b0; #1;
      check("beq_not", next_pc, 32'h104);
      pc_sel = c_BNE; imm = 16'd3; is_zero = 1'b0; #1;
      check("bne_taken", next_pc, 32'h110);
      step(c_BNE, 0, 0);
      check("bne_pc", pc, 32'h110);

      // J keeps upper PC bits, JR forces alignment and flags it
      step(c_JR, 32'h9000_0000, 0);
      step(c_J, 0, 26'h000_0010);
      check("j_pc", pc, 32'h9000_0040);
      step(c_JR, 32'h1237, 0);
      check("jr_mis_pc",  pc, 32'h1234);
      check("jr_mis_err", misalign_err, 1);

      // Nested calls and returns
      step(c_JR, 32'h200, 0);
      step(c_CALL, 0, 26'h0C0); check("call1", pc, 32'h300);
      step(c_CALL, 0, 26'h100); check("call2", pc, 32'h400);
      step(c_CALL, 0, 26'h140); check("call3", pc, 32'h500);
      step(c_RET, 32'h0, 0); check("ret1", pc, 32'h404);
      step(c_RET, 32'h0, 0); check("ret2", pc, 32'h304);
      step(c_RET, 32'h0, 0); check("ret3", pc, 32'h204);
      check("ret3_uf", ras_underflow, 0);
      step(c_RET, 32'h800, 0);
      check("ret4_pc", pc, 32'h800);
      check("ret4_uf", ras_underflow, 1);
      check("ret4_empty", ras_empty, 1);

      // Asynchronous reset in the middle of a cycle
      pc_sel = c_SEQ; #2;
      rst_n = 1'b0; #1;
      check("arst_pc",    pc, c_RV);
      check("arst_flags", {ras_overflow, ras_underflow, misalign_err}, 0);
      check("arst_empty", ras_empty, 1);
      #3; rst_n = 1'b1;
      @(negedge clk);

      // Overflow: five calls on a four-deep stack
      step(c_CALL, 0, 26'h100); check("ov_c1", pc, 32'h400);
      step(c_CALL, 0, 26'h140);
      step(c_CALL, 0, 26'h180);
      step(c_CALL, 0, 26'h1C0);
      check("ov_full4", ras_full, 1);
      check("ov_flag4", ras_overflow, 0);
      step(c_CALL, 0, 26'h200); check("ov_c5", pc, 32'h800);
      check("ov_full5", ras_full, 1);
      check("ov_flag5", ras_overflow, 1);
      step(c_RET, 32'hABC0, 0); check("ov_r1", pc, 32'h704);
      check("ov_notfull", ras_full, 0);
      step(c_RET, 32'hABC0, 0); check("ov_r2", pc, 32'h604);
      step(c_RET, 32'hABC0, 0); check("ov_r3", pc, 32'h504);
      step(c_RET, 32'hABC0, 0); check("ov_r4", pc, 32'h404);
      check("ov_empty", ras_empty, 1);
      check("ov_nouf", ras_underflow, 0);

      // Stall holds PC and stack while next_pc stays live
      stall = 1'b1;
      step(c_CALL, 0, 26'h300);
      check("stall_pc",    pc, 32'h404);
      check("stall_empty", ras_empty, 1);
      check("stall_next",  next_pc, 32'hC00);
      stall = 1'b0;
      step(c_CALL, 0, 26'h300);
      check("unstall_pc",    pc, 32'hC00);
      check("unstall_empty", ras_empty, 0);
      step(c_RET, 32'h0, 0);
      check("unstall_ret", pc, 32'h408);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
